// File: rtl/arm_ctrl_pkg.sv
// Shared control-unit types for the multicycle ARM datapath.
// Holds the main FSM state encoding and the ALU source / result mux select codes.
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  // ALUSrcB selects: register operand, extended immediate, constant four
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ResultSrc selects: registered ALU output, memory read data, live ALU result
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] OP_DP     = 2'b00;
  localparam logic [1:0] OP_MEM    = 2'b01;
  localparam logic [1:0] OP_BRANCH = 2'b10;

endpackage

// File: rtl/multicycle_main_fsm_decode.sv
// Purely combinational Moore decode of the main FSM state into datapath controls.
// InstrDone is the only output that also looks at inputs (Op for undefined retire, Stall).
module multicycle_main_fsm_decode
  import arm_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [1:0] Op,
  input  logic       Stall,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       InstrDone
);

  always_comb begin
    IRWrite   = 1'b0;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    ALUOp     = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_REG;
    ResultSrc = RES_ALUOUT;
    case (state)
      FETCH: begin
        IRWrite   = 1'b1;
        NextPC    = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      MEMADR:   ALUSrcB = SRCB_IMM;
      MEMREAD:  AdrSrc  = 1'b1;
      MEMWB: begin
        ResultSrc = RES_DATA;
        RegW      = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      EXECUTER: ALUOp = 1'b1;
      EXECUTEI: begin
        ALUOp   = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      ALUWB:    RegW = 1'b1;
      BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        Branch    = 1'b1;
      end
      default: ;
    endcase
  end

  // An undefined opcode retires straight out of DECODE
  always_comb begin
    InstrDone = 1'b0;
    if (!Stall) begin
      case (state)
        MEMWB, MEMWRITE, ALUWB, BRANCH: InstrDone = 1'b1;
        DECODE:                         InstrDone = (Op == 2'b11);
        default:                        InstrDone = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multicycle ARM processor: state register and sequencing.
// Output decoding lives in multicycle_main_fsm_decode.
module multicycle_main_fsm
  import arm_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       Stall,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       InstrDone,
  output logic [3:0] StateOut
);

  state_t state;
  state_t next;

  // Only the I and L bits steer sequencing; the rest belong to the ALU decoder
  logic unused_funct;
  assign unused_funct = ^Funct[4:1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= FETCH;
    else if (!Stall)
      state <= next;
  end

  // Unused encodings fall through the default and recover to FETCH
  always_comb begin
    next = FETCH;
    case (state)
      FETCH: next = DECODE;
      DECODE: begin
        case (Op)
          OP_DP:     next = Funct[5] ? EXECUTEI : EXECUTER;
          OP_MEM:    next = MEMADR;
          OP_BRANCH: next = BRANCH;
          default:   next = FETCH;
        endcase
      end
      MEMADR:   next = Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  next = MEMWB;
      EXECUTER: next = ALUWB;
      EXECUTEI: next = ALUWB;
      default:  next = FETCH;
    endcase
  end

  multicycle_main_fsm_decode u_decode (
    .state     (state),
    .Op        (Op),
    .Stall     (Stall),
    .IRWrite   (IRWrite),
    .NextPC    (NextPC),
    .RegW      (RegW),
    .MemW      (MemW),
    .Branch    (Branch),
    .ALUOp     (ALUOp),
    .AdrSrc    (AdrSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc),
    .InstrDone (InstrDone)
  );

  assign StateOut = state;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Self-checking bench for multicycle_main_fsm: an instruction-path model is
// compared against the DUT on every falling edge, plus hand-computed latencies.
module tb_multicycle_main_fsm;
  import arm_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'b000000;
  logic       Stall = 1'b0;
  logic       IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc, ALUSrcA;
  logic [1:0] ALUSrcB, ResultSrc;
  logic       InstrDone;
  logic [3:0] StateOut;

  int checks = 0;
  int failures = 0;
  int pos = 0;

  multicycle_main_fsm dut (
    .clk       (clk),
    .reset     (reset),
    .Op        (Op),
    .Funct     (Funct),
    .Stall     (Stall),
    .IRWrite   (IRWrite),
    .NextPC    (NextPC),
    .RegW      (RegW),
    .MemW      (MemW),
    .Branch    (Branch),
    .ALUOp     (ALUOp),
    .AdrSrc    (AdrSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc),
    .InstrDone (InstrDone),
    .StateOut  (StateOut)
  );

  always #5 clk = ~clk;

  // Instruction walk: the ordered list of states an instruction visits
  function automatic int pathLen(logic [1:0] op, logic [5:0] f);
    case (op)
      2'b00:   return 4;
      2'b01:   return f[0] ? 5 : 4;
      2'b10:   return 3;
      default: return 2;
    endcase
  endfunction

  function automatic state_t stateAt(logic [1:0] op, logic [5:0] f, int p);
    state_t dp[4]  = '{FETCH, DECODE, EXECUTER, ALUWB};
    state_t dpi[4] = '{FETCH, DECODE, EXECUTEI, ALUWB};
    state_t ld[5]  = '{FETCH, DECODE, MEMADR, MEMREAD, MEMWB};
    state_t st[4]  = '{FETCH, DECODE, MEMADR, MEMWRITE};
    state_t br[3]  = '{FETCH, DECODE, BRANCH};
    state_t ud[2]  = '{FETCH, DECODE};
    case (op)
      2'b00:   return f[5] ? dpi[p] : dp[p];
      2'b01:   return f[0] ? ld[p] : st[p];
      2'b10:   return br[p];
      default: return ud[p];
    endcase
  endfunction

  // {IRWrite,NextPC,RegW,MemW,Branch,ALUOp,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc}
  function automatic logic [11:0] expOutputs(state_t s);
    case (s)
      FETCH:    return 12'b1100_0001_1010;
      DECODE:   return 12'b0000_0001_1010;
      MEMADR:   return 12'b0000_0000_0100;
      MEMREAD:  return 12'b0000_0010_0000;
      MEMWB:    return 12'b0010_0000_0001;
      MEMWRITE: return 12'b0001_0010_0000;
      EXECUTER: return 12'b0000_0100_0000;
      EXECUTEI: return 12'b0000_0100_0100;
      ALUWB:    return 12'b0010_0000_0000;
      BRANCH:   return 12'b0000_1000_0110;
      default:  return 12'b0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model advances one step along the path per unstalled edge
  always @(posedge clk or posedge reset) begin
    if (reset)
      pos <= 0;
    else if (!Stall)
      pos <= (pos + 1 >= pathLen(Op, Funct)) ? 0 : pos + 1;
  end

  always @(negedge clk) begin
    state_t es;
    logic   ed;
    es = stateAt(Op, Funct, pos);
    ed = !Stall && (es == MEMWB || es == MEMWRITE || es == ALUWB || es == BRANCH ||
                    (es == DECODE && Op == 2'b11));
    checkOutput("state", StateOut, es);
    checkOutput("outputs", {IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc, ALUSrcA,
                            ALUSrcB, ResultSrc}, expOutputs(es));
    checkOutput("instrDone", InstrDone, ed);
  end

  // Runs one instruction starting just after an edge in FETCH; optional stall in one state
  task automatic applyStimulus(input string name, input logic [1:0] op, input logic [5:0] f,
                               input state_t stallState, input int stallN, input int expLat);
    int cyc = 0;
    bit done = 0;
    int sn = stallN;
    Op = op;
    Funct = f;
    for (int k = 0; k < 40 && !done; k++) begin
      if (sn > 0 && StateOut == stallState) begin
        Stall = 1'b1;
        repeat (sn) begin
          @(posedge clk);
          #1;
          checkOutput({name, "_stallHold"}, StateOut, stallState);
          checkOutput({name, "_stallDone"}, InstrDone, 0);
          if (stallState == MEMREAD) checkOutput({name, "_stallAdr"}, AdrSrc, 1);
        end
        Stall = 1'b0;
        sn = 0;
      end
      @(negedge clk);
      cyc++;
      if (InstrDone) done = 1;
      @(posedge clk);
      #1;
    end
    checkOutput({name, "_retired"}, done, 1);
    checkOutput({name, "_latency"}, cyc, expLat);
    checkOutput({name, "_backToFetch"}, StateOut, FETCH);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("resetState", StateOut, FETCH);
    checkOutput("resetIRWrite", IRWrite, 1);
    checkOutput("resetDone", InstrDone, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    applyStimulus("add",     2'b00, 6'b000000, FETCH,   0, 4);
    applyStimulus("ldrStall", 2'b01, 6'b011001, MEMREAD, 3, 5);
    applyStimulus("str",     2'b01, 6'b011000, FETCH,   0, 4);
    applyStimulus("branch",  2'b10, 6'b000000, FETCH,   0, 3);
    applyStimulus("undef",   2'b11, 6'b000000, FETCH,   0, 2);
    applyStimulus("undefStall", 2'b11, 6'b000000, DECODE, 2, 2);
    applyStimulus("addImm",  2'b00, 6'b100000, FETCH,   0, 4);
    applyStimulus("ldr",     2'b01, 6'b011001, FETCH,   0, 5);

    // Asynchronous reset in the middle of an immediate data-processing instruction
    Op = 2'b00;
    Funct = 6'b100000;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checkOutput("midInstrState", StateOut, EXECUTEI);
    #2 reset = 1'b1;
    #1;
    checkOutput("asyncResetState", StateOut, FETCH);
    checkOutput("asyncResetIRWrite", IRWrite, 1);
    checkOutput("asyncResetDone", InstrDone, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus("afterReset", 2'b10, 6'b000000, FETCH, 0, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
